// File: rtl/trap_csr_u_pkg.sv
// rtl/trap_csr_u_pkg.sv - shared constants and types for the M-mode trap/CSR unit
//
// Purpose : exception cause codes, CSR addresses, mcause codes, csr_op
//           encodings, mstatus bit positions and the unit's FSM state type.
// Ports   : none (package).
// Option  : TRAP_CSR_MCYCLE_EN enables the mcycle/mcycleh addresses in the top.
package trap_csr_u_pkg;

    // Exception causes as delivered by the ID-stage exception control unit.
    localparam logic [1:0] NOT_EXCEPTION       = 2'd0;
    localparam logic [1:0] I_ADDR_MISALIGNMENT = 2'd1;
    localparam logic [1:0] ECALL               = 2'd2;

    // CSR addresses.
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    // mcause codes.
    localparam logic [31:0] MCAUSE_I_ADDR_MISALIGNED = 32'd0;
    localparam logic [31:0] MCAUSE_ECALL_M           = 32'd11;

    // csr_op encodings.
    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RW   = 2'b01;
    localparam logic [1:0] CSR_OP_RS   = 2'b10;
    localparam logic [1:0] CSR_OP_RC   = 2'b11;

    // mstatus bit indices.
    localparam int MSTATUS_MIE_BIT    = 3;
    localparam int MSTATUS_MPIE_BIT   = 7;
    localparam int MSTATUS_MPP_LO_BIT = 11;
    localparam int MSTATUS_MPP_HI_BIT = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_t;

    // Only ECALL has a non-zero code; any other raised cause is treated as
    // an instruction address misalignment.
    function automatic logic [31:0] cause_to_mcause(input logic [1:0] cause);
        return (cause == ECALL) ? MCAUSE_ECALL_M : MCAUSE_I_ADDR_MISALIGNED;
    endfunction

endpackage

// File: rtl/trap_csr_u_if.sv
// rtl/trap_csr_u_if.sv - pipeline-side bundle for the M-mode trap/CSR unit
//
// Purpose : groups exception inputs, CSR access and redirect outputs.
// Signals : e_raised/e_cause/e_pc/e_tval  exception from ID
//           is_mret                       MRET committing
//           csr_op/csr_addr/csr_wdata     CSR access request
//           csr_rdata                     pre-write CSR value (combinational)
//           redirect/redirect_pc/flush    one-cycle PC redirect + IF/ID flush
// Modports: master = pipeline, slave = trap_csr_u.
interface trap_csr_u_if;
    logic        e_raised;
    logic [1:0]  e_cause;
    logic [31:0] e_pc;
    logic [31:0] e_tval;
    logic        is_mret;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        output e_raised, e_cause, e_pc, e_tval, is_mret,
        output csr_op, csr_addr, csr_wdata,
        input  csr_rdata, redirect, redirect_pc, flush
    );

    modport slave (
        input  e_raised, e_cause, e_pc, e_tval, is_mret,
        input  csr_op, csr_addr, csr_wdata,
        output csr_rdata, redirect, redirect_pc, flush
    );
endinterface

// File: rtl/trap_csr_u_csr_wdata_alu.sv
// rtl/trap_csr_u_csr_wdata_alu.sv - CSRRW/CSRRS/CSRRC write-value merge
//
// Purpose : combinational merge of the old CSR value with rs1.
// Ports   : i_op    csr_op encoding
//           i_old   current CSR value
//           i_wdata rs1 value
//           o_new   value to be written
module trap_csr_u_csr_wdata_alu
    import trap_csr_u_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_new
);
    always_comb begin
        o_new = i_old;
        unique case (i_op)
            CSR_OP_RW:   o_new = i_wdata;
            CSR_OP_RS:   o_new = i_old | i_wdata;
            CSR_OP_RC:   o_new = i_old & ~i_wdata;
            CSR_OP_NONE: o_new = i_old;
        endcase
    end
endmodule

// File: rtl/trap_csr_u.sv
// rtl/trap_csr_u.sv - machine-mode trap and CSR unit
//
// Purpose : holds mstatus/mtvec/mscratch/mepc/mcause/mtval, latches trap
//           state on an exception, redirects to mtvec on a trap or to mepc
//           on MRET (one-cycle redirect+flush), serves CSRRW/RS/RC.
// Ports   : clk  clock
//           rst  synchronous active-high reset
//           bus  trap_csr_u_if.slave (exception, MRET, CSR access, redirect)
// Params  : MTVEC_RESET reset value of mtvec (bits [1:0] dropped)
// Option  : TRAP_CSR_MCYCLE_EN adds a 64-bit mcycle at 0xB00/0xB80.
module trap_csr_u
    import trap_csr_u_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    trap_csr_u_if.slave bus
);

    trap_state_t r_state;
    trap_state_t w_state_nxt;

    logic        r_mie;
    logic        r_mpie;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_redirect_pc;
`ifdef TRAP_CSR_MCYCLE_EN
    logic [63:0] r_mcycle;
`endif

    logic        w_take_trap;
    logic        w_take_mret;
    logic        w_csr_we;
    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_unused_ok;

    // e_pc[1:0] is never stored: mepc is word aligned.
    assign w_unused_ok = ^bus.e_pc[1:0];

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and event arbitration. In REDIR everything arriving is
    // wrong-path and being flushed, so traps, MRET and CSR writes are all
    // ignored there. In IDLE: trap > MRET > CSR write.
    always_comb begin
        w_state_nxt = r_state;
        w_take_trap = 1'b0;
        w_take_mret = 1'b0;
        w_csr_we    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.e_raised) begin
                    w_take_trap = 1'b1;
                    w_state_nxt = ST_REDIR;
                end else if (bus.is_mret) begin
                    w_take_mret = 1'b1;
                    w_state_nxt = ST_REDIR;
                end else begin
                    w_csr_we = (bus.csr_op != CSR_OP_NONE);
                end
            end
            ST_REDIR: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.redirect    = (r_state == ST_REDIR);
    assign bus.flush       = (r_state == ST_REDIR);
    assign bus.redirect_pc = r_redirect_pc;

    // ---------------------------------------------------------------
    // CSR read mux (pre-write value, always driven)
    // ---------------------------------------------------------------
    always_comb begin
        w_mstatus                                        = '0;
        w_mstatus[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
        w_mstatus[MSTATUS_MPIE_BIT]                      = r_mpie;
        w_mstatus[MSTATUS_MIE_BIT]                       = r_mie;
    end

    always_comb begin
        w_old = '0;
        case (bus.csr_addr)
            CSR_MSTATUS:  w_old = w_mstatus;
            CSR_MTVEC:    w_old = {r_mtvec, 2'b00};
            CSR_MSCRATCH: w_old = r_mscratch;
            CSR_MEPC:     w_old = {r_mepc, 2'b00};
            CSR_MCAUSE:   w_old = r_mcause;
            CSR_MTVAL:    w_old = r_mtval;
`ifdef TRAP_CSR_MCYCLE_EN
            CSR_MCYCLE:   w_old = r_mcycle[31:0];
            CSR_MCYCLEH:  w_old = r_mcycle[63:32];
`endif
            default:      w_old = '0;
        endcase
    end

    assign bus.csr_rdata = w_old;

    trap_csr_u_csr_wdata_alu u_wdata_alu (
        .i_op    (bus.csr_op),
        .i_old   (w_old),
        .i_wdata (bus.csr_wdata),
        .o_new   (w_new)
    );

    // ---------------------------------------------------------------
    // Trap CSR state
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= MTVEC_RESET[31:2];
            r_mscratch    <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
        end else if (w_take_trap) begin
            // mtvec is read as currently held, so a same-cycle mtvec write
            // (which is dropped anyway) cannot affect this trap's target.
            r_mepc        <= bus.e_pc[31:2];
            r_mcause      <= cause_to_mcause(bus.e_cause);
            r_mtval       <= bus.e_tval;
            r_mpie        <= r_mie;
            r_mie         <= 1'b0;
            r_redirect_pc <= {r_mtvec, 2'b00};
        end else if (w_take_mret) begin
            r_mie         <= r_mpie;
            r_mpie        <= 1'b1;
            r_redirect_pc <= {r_mepc, 2'b00};
        end else if (w_csr_we) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE_BIT];
                    r_mpie <= w_new[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:    r_mtvec    <= w_new[31:2];
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc     <= w_new[31:2];
                CSR_MCAUSE:   r_mcause   <= w_new;
                CSR_MTVAL:    r_mtval    <= w_new;
                default: ;
            endcase
        end
    end

`ifdef TRAP_CSR_MCYCLE_EN
    // A write to either half replaces it and suppresses that cycle's count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle <= '0;
        end else if (w_csr_we && (bus.csr_addr == CSR_MCYCLE)) begin
            r_mcycle[31:0] <= w_new;
        end else if (w_csr_we && (bus.csr_addr == CSR_MCYCLEH)) begin
            r_mcycle[63:32] <= w_new;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trap_csr_u.sv
// tb/tb_trap_csr_u.sv - scoreboard bench for trap_csr_u
module tb_trap_csr_u;
    import trap_csr_u_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_csr_u_if bus ();

    trap_csr_u #(.MTVEC_RESET(32'h0000_1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        int          at;
    } redir_t;

    redir_t      redir_q[$];
    logic [31:0] rdata_q[$];

    // Reference model: architectural CSR contents plus "next cycle is flushed".
    bit          m_mie, m_mpie, m_redir;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_redir = 0;
        m_mtvec = 32'h0000_1000;
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h305: m_mtvec = v & 32'hFFFF_FFFC;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & 32'hFFFF_FFFC;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            default: ;
        endcase
    endtask

    // Drive one cycle of stimulus, record expectations, advance the clock.
    task automatic step(input bit er, input logic [1:0] ec, input logic [31:0] epc,
                        input logic [31:0] etv, input bit mret, input logic [1:0] op,
                        input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] old;
        logic [31:0] nv;
        redir_t r;
        bus.e_raised = er; bus.e_cause = ec; bus.e_pc = epc; bus.e_tval = etv;
        bus.is_mret = mret; bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wd;
        old = m_read(addr);
        if (op != 2'b00) rdata_q.push_back(old);
        if (m_redir) begin
            m_redir = 0;
        end else if (er) begin
            m_mepc   = epc & 32'hFFFF_FFFC;
            m_mcause = (ec == ECALL) ? 32'd11 : 32'd0;
            m_mtval  = etv;
            m_mpie   = m_mie;
            m_mie    = 0;
            r.pc = m_mtvec; r.at = cyc + 1;
            redir_q.push_back(r);
            m_redir = 1;
        end else if (mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
            r.pc = m_mepc; r.at = cyc + 1;
            redir_q.push_back(r);
            m_redir = 1;
        end else if (op != 2'b00) begin
            if (op == 2'b01)      nv = wd;
            else if (op == 2'b10) nv = old | wd;
            else                  nv = old & ~wd;
            m_write(addr, nv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 2'd0, 0, 0, 0, 2'b00, 12'h000, 0);
    endtask

    task automatic rd(input logic [11:0] a);
        step(0, 2'd0, 0, 0, 0, 2'b10, a, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.e_raised = 0; bus.e_cause = 0; bus.e_pc = 0; bus.e_tval = 0;
        bus.is_mret = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.redirect !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL %s: redirect=%b flush=%b redirect_pc=%h, required 0/0/00000000",
                     tag, bus.redirect, bus.flush, bus.redirect_pc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a redirect or
    // answers a CSR access.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (bus.flush !== bus.redirect) begin
                errors++;
                $display("FAIL flush_eq_redirect cyc %0d: flush=%b redirect=%b", cyc, bus.flush, bus.redirect);
            end
            if (bus.redirect === 1'b1) begin
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect cyc %0d: redirect_pc=%h, required no redirect", cyc, bus.redirect_pc);
                end else begin
                    redir_t e;
                    e = redir_q.pop_front();
                    if (bus.redirect_pc !== e.pc || cyc != e.at) begin
                        errors++;
                        $display("FAIL redirect cyc %0d: pc=%h, required pc=%h at cyc %0d", cyc, bus.redirect_pc, e.pc, e.at);
                    end
                end
            end else if (redir_q.size() != 0 && redir_q[0].at <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_redirect cyc %0d: redirect=%b, required redirect to %h", cyc, bus.redirect, redir_q[0].pc);
                void'(redir_q.pop_front());
            end
            if (!rst && bus.csr_op != 2'b00) begin
                checks++;
                if (rdata_q.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_queue cyc %0d: no expectation for csr access", cyc);
                end else begin
                    logic [31:0] e;
                    e = rdata_q.pop_front();
                    if (bus.csr_rdata !== e) begin
                        errors++;
                        $display("FAIL csr_rdata cyc %0d addr %h: got %h, required %h", cyc, bus.csr_addr, bus.csr_rdata, e);
                    end
                end
            end
        end
    end

    logic [11:0] addr_tab [10] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'h344, 12'h7FF, 12'hB00, 12'hB80};

    initial begin
        int hi;
`ifdef TRAP_CSR_MCYCLE_EN
        hi = 7;
`else
        hi = 9;
`endif
        bus.e_raised = 0; bus.e_cause = 0; bus.e_pc = 0; bus.e_tval = 0;
        bus.is_mret = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_reset_outputs("reset_outputs");
        mon_en = 1;

        rd(12'h305);
        rd(12'h300);

        // ECALL with MIE set
        step(0, 0, 0, 0, 0, 2'b10, 12'h300, 32'h8);
        step(1, ECALL, 32'h124, 32'h0, 0, 2'b00, 12'h000, 0);
        idle();
        rd(12'h341); rd(12'h342); rd(12'h343); rd(12'h300);

        // MRET back to mepc
        step(0, 0, 0, 0, 1, 2'b00, 12'h000, 0);
        idle();
        rd(12'h300);

        // misaligned fetch trap
        step(1, I_ADDR_MISALIGNMENT, 32'h202, 32'h202, 0, 2'b00, 12'h000, 0);
        idle();
        rd(12'h341); rd(12'h342); rd(12'h343);

        // mscratch RW/RS/RC
        step(0, 0, 0, 0, 0, 2'b01, 12'h340, 32'hF0F0_0000);
        step(0, 0, 0, 0, 0, 2'b10, 12'h340, 32'h0000_000F);
        step(0, 0, 0, 0, 0, 2'b11, 12'h340, 32'hF000_0000);
        rd(12'h340);

        // collision: trap beats CSR write, held e_raised in REDIR ignored
        step(1, ECALL, 32'h40, 32'h0, 0, 2'b01, 12'h341, 32'hDEAD_BEEC);
        step(1, ECALL, 32'h80, 32'h5, 1, 2'b01, 12'h341, 32'h1234_5678);
        rd(12'h341);

        // mtvec write seen by the next-cycle trap; back-to-back traps
        step(0, 0, 0, 0, 0, 2'b01, 12'h305, 32'h0000_2003);
        step(1, ECALL, 32'h300, 32'h0, 0, 2'b00, 12'h000, 0);
        idle();
        step(1, I_ADDR_MISALIGNMENT, 32'h306, 32'h306, 0, 2'b00, 12'h000, 0);
        idle();
        rd(12'h305); rd(12'h341);

        // unmapped accesses
        step(0, 0, 0, 0, 0, 2'b01, 12'h344, 32'hFFFF_FFFF);
        rd(12'h344);
        rd(12'hB00);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit er, mr;
            er = ($urandom_range(0, 9) == 0);
            mr = ($urandom_range(0, 9) == 0);
            step(er, 2'($urandom_range(1, 2)), $urandom, $urandom, mr,
                 2'($urandom_range(0, 3)), addr_tab[$urandom_range(0, hi)], $urandom);
        end

        // reset asserted while in REDIR
        idle();
        step(1, ECALL, 32'h500, 32'h0, 0, 2'b00, 12'h000, 0);
        do_reset();
        check_reset_outputs("reset_in_redir");
        rd(12'h305); rd(12'h300); rd(12'h341); rd(12'h340);

        idle(); idle();
        checks++;
        if (redir_q.size() != 0 || rdata_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: redirects left %0d, reads left %0d, required 0/0",
                     redir_q.size(), rdata_q.size());
        end
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
